// File: rtl/tx_buffer_serializer_if.sv
// rtl/tx_buffer_serializer_if.sv - byte-load bus between stimulus generator and tx buffer
//
// Ports (signals):
//   data_in     byte offered for enqueue
//   tx_buff_ld  load strobe, one byte per asserted clk edge
//   buff_empty  FIFO occupancy is zero
//   buff_full   FIFO occupancy equals DEPTH
//   overflow    one-cycle pulse after a dropped load
//   buff_count  current FIFO occupancy
// Modports: master = load driver, slave = tx_buffer_serializer.
interface tx_buffer_serializer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    data_in;
  logic          tx_buff_ld;
  logic          buff_empty;
  logic          buff_full;
  logic          overflow;
  logic [CW-1:0] buff_count;

  modport master (
    output data_in, tx_buff_ld,
    input  buff_empty, buff_full, overflow, buff_count
  );

  modport slave (
    input  data_in, tx_buff_ld,
    output buff_empty, buff_full, overflow, buff_count
  );
endinterface

// File: rtl/tx_buffer_serializer.sv
// rtl/tx_buffer_serializer.sv - byte FIFO feeding an async serial frame transmitter
//
// Frame: start(0), 8 data bits LSB first, [even parity], stop(1); each bit
// held CLKS_PER_BIT clocks. Optional parity bit enabled by macro TX_PARITY_EN.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   bus            load bus (slave modport): data_in/tx_buff_ld in, status out
//   tx_serial_out  registered serial line, idle high
//   tx_busy        high while the FSM is not IDLE
module tx_buffer_serializer #(
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  tx_buffer_serializer_if.slave  bus,
  output logic                   tx_serial_out,
  output logic                   tx_busy
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        r_state;
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_empty;
  logic          r_full;
  logic          r_overflow;
  logic [7:0]    r_shift;
  logic [BW-1:0] r_baud;
  logic [2:0]    r_bit;
  logic          r_line;
  logic          r_busy;
`ifdef TX_PARITY_EN
  logic          r_parity;
`endif

  logic          w_baud_done;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [CW-1:0] w_count_nxt;

  assign w_baud_done = (r_baud == BAUD_LAST);
  // Pops happen only when the shift register is free: in IDLE, or on the
  // last stop-bit clock so the next start bit follows with no idle gap.
  assign w_pop  = (r_count != '0) &&
                  ((r_state == IDLE) || ((r_state == STOP) && w_baud_done));
  // A full FIFO still accepts a load when the head leaves the same cycle.
  assign w_push = bus.tx_buff_ld && ((r_count != FULL_CNT) || w_pop);
  assign w_drop = bus.tx_buff_ld && !w_push;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (reset && w_push) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_shift    <= '0;
      r_baud     <= '0;
      r_bit      <= '0;
      r_line     <= 1'b1;
      r_busy     <= 1'b0;
`ifdef TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_overflow <= w_drop;
      r_count    <= w_count_nxt;
      r_empty    <= (w_count_nxt == '0);
      r_full     <= (w_count_nxt == FULL_CNT);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end

      // The line is driven from the current state, so it trails the
      // state register by one clock; every bit keeps its full width.
      case (r_state)
        IDLE: begin
          r_line <= 1'b1;
          r_baud <= '0;
          r_bit  <= '0;
          if (w_pop) begin
            r_state <= START;
            r_busy  <= 1'b1;
          end
        end
        START: begin
          r_line <= 1'b0;
          if (w_baud_done) begin
            r_baud  <= '0;
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          r_line <= r_shift[0];
          if (w_baud_done) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_bit <= '0;
`ifdef TX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`ifdef TX_PARITY_EN
        PARITY: begin
          r_line <= r_parity;
          if (w_baud_done) begin
            r_baud  <= '0;
            r_state <= STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif
        STOP: begin
          r_line <= 1'b1;
          if (w_baud_done) begin
            r_baud  <= '0;
            r_state <= w_pop ? START : IDLE;
            r_busy  <= w_pop;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_line  <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_shift  <= r_mem[r_rd_ptr];
`ifdef TX_PARITY_EN
        r_parity <= ^r_mem[r_rd_ptr];
`endif
      end
    end
  end

  assign tx_serial_out  = r_line;
  assign tx_busy        = r_busy;
  assign bus.buff_empty = r_empty;
  assign bus.buff_full  = r_full;
  assign bus.overflow   = r_overflow;
  assign bus.buff_count = r_count;
endmodule
